// File: rtl/cla_arb_pkg.sv
// Shared definitions for the round-robin arbitrated CLA adder subsystem.
// Holds the operand/sum widths, the default requester count and the
// arbiter state encoding.
package cla_arb_pkg;

  localparam int OP_W         = 8;
  localparam int SUM_W        = 9;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit signed carry-lookahead adder, purely combinational.
// Ports:
//   a, b : signed 8-bit operands (two's complement)
//   sum  : full 9-bit signed result a+b (cannot overflow)
module cla_8bit
  import cla_arb_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [SUM_W-1:0] sum
);

  logic [OP_W-1:0] g_s;
  logic [OP_W-1:0] p_s;
  logic [OP_W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | g[i-1]p[i] | g[i-2]p[i]p[i-1] | ...
  always_comb begin
    logic carry_s;
    logic prop_s;
    c_s     = '0;
    carry_s = 1'b0;
    prop_s  = 1'b0;
    for (int i = 0; i < OP_W; i++) begin
      carry_s = g_s[i];
      prop_s  = p_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry_s = carry_s | (g_s[j] & prop_s);
        prop_s  = prop_s & p_s[j];
      end
      c_s[i+1] = carry_s;
    end
  end

  // Bit 8 adds the sign-extended operand bits plus the final carry.
  assign sum = {a[OP_W-1] ^ b[OP_W-1] ^ c_s[OP_W], p_s ^ c_s[OP_W-1:0]};

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches req from ptr+1 upward, wrapping modulo NREQ, and returns the
// first set position.
// Ports:
//   req       : request vector
//   ptr       : index of the last winner (lowest priority this round)
//   any_grant : some request is set
//   grant     : one-hot winner (zero when no request)
//   idx       : encoded winner index
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  // Rotating first-hit search starting just after ptr.
  always_comb begin
    int cand_s;
    any_grant = 1'b0;
    grant     = '0;
    idx       = '0;
    cand_s    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(ptr) + k) % NREQ;
      if (!any_grant && req[cand_s]) begin
        any_grant     = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = IDW'(cand_s);
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/cla_rr_arbiter.sv
// Shares one cla_8bit adder between NREQ requesters with a round-robin
// grant and a registered, ID-tagged result port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand pair valid
//   req_ready  : per-requester accept (one-hot or zero, combinational)
//   req_a/b    : packed signed operands, requester i at [8i+7:8i]
//   res_valid  : registered result valid
//   res_ready  : result consumer accept
//   res_sum    : registered 9-bit signed sum
//   res_id     : requester that produced res_sum
module cla_rr_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SUM_W-1:0]     res_sum,
  output logic [IDW-1:0]       res_id
);

  arb_state_t       state_r;
  arb_state_t       state_n_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic             res_valid_r;
  logic [SUM_W-1:0] res_sum_r;
  logic [IDW-1:0]   res_id_r;

  logic             can_accept_s;
  logic             any_s;
  logic [NREQ-1:0]  gnt_s;
  logic [IDW-1:0]   idx_s;
  logic             grant_s;
  logic [OP_W-1:0]  op_a_s;
  logic [OP_W-1:0]  op_b_s;
  logic [SUM_W-1:0] sum_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .any_grant (any_s),
    .grant     (gnt_s),
    .idx       (idx_s)
  );

  // A new pair can be taken when nothing is held or the held one leaves now.
  always_comb begin
    can_accept_s = 1'b0;
    case (state_r)
      IDLE:    can_accept_s = 1'b1;
      HOLD:    can_accept_s = res_ready;
      default: can_accept_s = 1'b0;
    endcase
  end

  // Reset suppresses the grant so no requester sees an accept that is lost.
  assign grant_s   = can_accept_s & any_s & ~rst;
  assign req_ready = grant_s ? gnt_s : '0;

  assign op_a_s = req_a[idx_s*OP_W +: OP_W];
  assign op_b_s = req_b[idx_s*OP_W +: OP_W];

  cla_8bit u_add (
    .a   (op_a_s),
    .b   (op_b_s),
    .sum (sum_s)
  );

  // Next-state: HOLD while a result is loaded or still waiting to drain.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_n_s = HOLD;
        end else begin
          state_n_s = IDLE;
        end
      end
      HOLD: begin
        if (res_ready && !grant_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = HOLD;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State, priority pointer and result registers; sum/id persist after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= IDW'(NREQ - 1);
      res_valid_r <= 1'b0;
      res_sum_r   <= '0;
      res_id_r    <= '0;
    end else begin
      state_r <= state_n_s;
      if (grant_s) begin
        res_valid_r <= 1'b1;
        res_sum_r   <= sum_s;
        res_id_r    <= idx_s;
        rr_ptr_r    <= idx_s;
      end else if (state_r == HOLD && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_id    = res_id_r;

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// Self-checking bench for cla_rr_arbiter (NREQ=4): a directed vector table,
// a fairness-after-reset sequence and a randomized run against a
// transaction-level model of the arbiter.
module tb_cla_rr_arbiter;

  localparam int N = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*8-1:0]    req_a;
  logic [N*8-1:0]    req_b;
  logic              res_valid;
  logic              res_ready;
  logic [8:0]        res_sum;
  logic [1:0]        res_id;

  cla_rr_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // Per-lane operands currently offered.
  logic signed [7:0] a_lane [N];
  logic signed [7:0] b_lane [N];

  // Model: is a result held, its value and owner, and the last winner.
  bit m_has;
  int m_sum;
  int m_id;
  int m_last;

  typedef struct {
    logic [3:0] v;
    logic [7:0] a;
    logic [7:0] b;
    logic       rr;
    logic       r;
    logic [3:0] er;
    logic       ev;
    logic [8:0] es;
    logic [1:0] eid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check combinational accept, clock, check results.
  task automatic run_cycle(input logic [3:0] v, input logic r, input logic rr,
                           output logic [3:0] act_rdy);
    logic [3:0] exp_rdy;
    logic [8:0] exp_sum;
    int g;
    int c;
    @(negedge clk);
    req_valid = v;
    rst       = r;
    res_ready = rr;
    req_a     = {a_lane[3], a_lane[2], a_lane[1], a_lane[0]};
    req_b     = {b_lane[3], b_lane[2], b_lane[1], b_lane[0]};
    #1;
    exp_rdy = '0;
    g = -1;
    if (!r && (!m_has || rr)) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    act_rdy = req_ready;
    chk("req_ready", {28'd0, act_rdy}, {28'd0, exp_rdy});
    @(posedge clk);
    #1;
    if (r) begin
      m_has = 1'b0; m_sum = 0; m_id = 0; m_last = N - 1;
    end else if (g >= 0) begin
      m_has = 1'b1;
      m_sum = int'(a_lane[g]) + int'(b_lane[g]);
      m_id = g;
      m_last = g;
    end else if (m_has && rr) begin
      m_has = 1'b0;
    end
    exp_sum = 9'(m_sum);
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_has});
    chk("res_sum", {23'd0, res_sum}, {23'd0, exp_sum});
    chk("res_id", {30'd0, res_id}, 32'(m_id));
  endtask

  initial begin
    logic [3:0] rdy;
    logic [3:0] pend;

    rst = 1'b1; req_valid = '0; res_ready = 1'b0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin a_lane[i] = '0; b_lane[i] = '0; end
    m_has = 1'b0; m_sum = 0; m_id = 0; m_last = N - 1;

    // Directed table: {valid, a, b, res_ready, rst, exp_ready, exp_valid, exp_sum, exp_id}
    tbl.push_back('{4'b0001, 8'h7F, 8'h01, 1'b1, 1'b0, 4'b0001, 1'b1, 9'h080, 2'd0});
    tbl.push_back('{4'b0100, 8'h80, 8'h80, 1'b1, 1'b0, 4'b0100, 1'b1, 9'h100, 2'd2});
    tbl.push_back('{4'b0100, 8'hFF, 8'h01, 1'b1, 1'b0, 4'b0100, 1'b1, 9'h000, 2'd2});
    tbl.push_back('{4'b0000, 8'h00, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 9'h000, 2'd2});
    tbl.push_back('{4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 9'h000, 2'd2});
    tbl.push_back('{4'b1111, 8'h01, 8'h02, 1'b1, 1'b0, 4'b1000, 1'b1, 9'h003, 2'd3});
    tbl.push_back('{4'b1111, 8'h01, 8'h02, 1'b1, 1'b0, 4'b0001, 1'b1, 9'h003, 2'd0});
    tbl.push_back('{4'b1111, 8'h01, 8'h02, 1'b1, 1'b0, 4'b0010, 1'b1, 9'h003, 2'd1});
    tbl.push_back('{4'b1111, 8'h01, 8'h02, 1'b1, 1'b0, 4'b0100, 1'b1, 9'h003, 2'd2});
    tbl.push_back('{4'b1111, 8'h10, 8'h10, 1'b0, 1'b0, 4'b0000, 1'b1, 9'h003, 2'd2});
    tbl.push_back('{4'b1111, 8'h10, 8'h10, 1'b0, 1'b0, 4'b0000, 1'b1, 9'h003, 2'd2});
    tbl.push_back('{4'b1111, 8'h10, 8'h10, 1'b0, 1'b0, 4'b0000, 1'b1, 9'h003, 2'd2});
    tbl.push_back('{4'b1111, 8'h10, 8'h10, 1'b1, 1'b0, 4'b1000, 1'b1, 9'h020, 2'd3});
    tbl.push_back('{4'b0010, 8'h05, 8'h05, 1'b1, 1'b0, 4'b0010, 1'b1, 9'h00A, 2'd1});
    tbl.push_back('{4'b0010, 8'h05, 8'h05, 1'b1, 1'b0, 4'b0010, 1'b1, 9'h00A, 2'd1});
    tbl.push_back('{4'b0011, 8'h05, 8'h05, 1'b1, 1'b0, 4'b0001, 1'b1, 9'h00A, 2'd0});
    tbl.push_back('{4'b0011, 8'h05, 8'h05, 1'b1, 1'b0, 4'b0010, 1'b1, 9'h00A, 2'd1});
    tbl.push_back('{4'b0100, 8'h05, 8'h05, 1'b1, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0});
    tbl.push_back('{4'b0110, 8'h02, 8'hFD, 1'b1, 1'b0, 4'b0010, 1'b1, 9'h1FF, 2'd1});

    // Reset values.
    run_cycle(4'b0000, 1'b1, 1'b0, rdy);
    run_cycle(4'b0000, 1'b1, 1'b0, rdy);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sum", {23'd0, res_sum}, 32'd0);
    chk("rst_id", {30'd0, res_id}, 32'd0);

    foreach (tbl[t]) begin
      for (int i = 0; i < N; i++) begin a_lane[i] = tbl[t].a; b_lane[i] = tbl[t].b; end
      run_cycle(tbl[t].v, tbl[t].r, tbl[t].rr, rdy);
      chk("tbl_ready", {28'd0, rdy}, {28'd0, tbl[t].er});
      chk("tbl_valid", {31'd0, res_valid}, {31'd0, tbl[t].ev});
      chk("tbl_sum", {23'd0, res_sum}, {23'd0, tbl[t].es});
      chk("tbl_id", {30'd0, res_id}, {30'd0, tbl[t].eid});
    end

    // Fairness right after reset: 0,1,2,3,0,1,2,3 with no bubble.
    run_cycle(4'b0000, 1'b1, 1'b1, rdy);
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < N; l++) begin
        a_lane[l] = 8'($urandom); b_lane[l] = 8'($urandom);
      end
      run_cycle(4'b1111, 1'b0, 1'b1, rdy);
      chk("fair_id", {30'd0, res_id}, 32'(i % N));
      chk("fair_valid", {31'd0, res_valid}, 32'd1);
    end

    // Randomized traffic; requesters hold their pair until accepted.
    pend = '0;
    for (int n = 0; n < 500; n++) begin
      for (int l = 0; l < N; l++) begin
        if (!pend[l] && ($urandom_range(0, 1) == 1)) begin
          pend[l] = 1'b1;
          a_lane[l] = 8'($urandom);
          b_lane[l] = 8'($urandom);
        end
      end
      run_cycle(pend, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rdy);
      pend = pend & ~rdy;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/cla_rr_arbiter.md
Name: cla_rr_arbiter

Overview:
- Shares one cla_8bit signed adder between NREQ requesters.
- Each requester offers a signed 8-bit operand pair with a valid/ready handshake.
- A round-robin grant selects one pair per cycle. The 9-bit signed sum is registered and presented on a single result port, tagged with the requester ID.
- Sits between the requesting datapath blocks and the adder; it is the only instantiator of cla_8bit in that subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*8  packed signed operand A; requester i uses bits [8i+7:8i].
- req_b  in  NREQ*8  packed signed operand B; same packing as req_a.
- res_valid  out  1  registered result valid.
- res_ready  in  1  result consumer accept.
- res_sum  out  9  registered signed sum a+b, sign-extended to 9 bits.
- res_id  out  IDW  index of the requester that produced res_sum.

Behaviour:
- Reset values: res_valid=0, res_sum=0, res_id=0, state=IDLE, rr_ptr=NREQ-1. With rr_ptr=NREQ-1, requester 0 has first priority after reset.
- FSM states:
  - IDLE: no result held.
  - HOLD: result held on res_* with res_valid=1.
- can_accept = (state==IDLE) || (state==HOLD && res_ready).
- Grant:
  - When can_accept and |req_valid, grant g = the first i with req_valid[i] set, searching from rr_ptr+1 upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle; all other req_ready bits are 0.
  - If can_accept=0 or req_valid==0, req_ready=0.
- Handshake: a transfer occurs on a requester when req_valid[i] && req_ready[i] at the clock edge.
  - Requesters must hold req_a, req_b and req_valid stable until accepted.
  - The arbiter never grants a requester whose valid is low.
- Datapath: the granted pair is muxed to one cla_8bit instance, which is combinational. On a grant edge:
  - res_sum <= adder sum
  - res_id <= g
  - rr_ptr <= g
  - state <= HOLD, res_valid <= 1
- Latency: result visible exactly 1 cycle after the accepting edge.
- Throughput: 1 op/cycle sustained when res_ready is held at 1.
- HOLD transitions:
  - res_ready=1 with a new grant: stay in HOLD and load the new result. This is back-to-back operation with no bubble.
  - res_ready=1 with no request: go to IDLE, res_valid <= 0. res_sum and res_id keep their last values.
  - res_ready=0: all res_* outputs held stable and req_ready=0 (backpressure).
- Arithmetic:
  - Operands are two's complement.
  - res_sum is the full 9-bit result, so overflow is impossible. Range is -256..+254.
- Fairness: with all requesters valid continuously and res_ready=1, grant order is 0,1,..,NREQ-1,0,...
  - A requester waits at most NREQ-1 grants.
- rr_ptr moves only on a grant. An idle cycle does not rotate priority.
- Simultaneous rst and any handshake: reset wins. No transfer is counted and the held result is discarded.
- Reset mid-HOLD: outputs return to reset values on the next edge.
- res_ready while in IDLE is ignored.

Decomposition:
- Package cla_arb_pkg holds:
  - localparam SUM_W=9 and OP_W=8
  - the typedef enum logic {IDLE, HOLD} arb_state_t
  - the default NREQ
- One natural sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: any_grant, one-hot grant, encoded index.
  - Parameterised by NREQ.
  - Verified standalone first.
- The top level holds the FSM, the operand mux, the cla_8bit instance and the result registers.

Test Plan:
- Reset, then req_valid=4'b0001 with a0=8'h7F, b0=8'h01 and res_ready=1 -> req_ready=4'b0001 on the same cycle; next cycle res_valid=1, res_sum=9'h080 (+128), res_id=0.
- Requester 2 with a=8'h80, b=8'h80 -> res_sum=9'h100 (-256), res_id=2. Then a=8'hFF, b=8'h01 -> res_sum=9'h000.
- All four requesters valid, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, res_valid continuously 1, no bubbles.
- A result is held and res_ready=0 for 3 cycles while req_valid=4'b1111 -> req_ready=0, res_sum and res_id stable. When res_ready rises, the next grant goes to (held id+1) mod 4.
- After a grant to id 1, req_valid=4'b0010 only, repeated -> id 1 granted every cycle; rr_ptr stays 1. Adding req 0 then grants 2-wrap order: 0 before 1.
- rst asserted in HOLD coincident with res_ready=1 and req_valid=4'b0100 -> next cycle res_valid=0, res_sum=0, res_id=0, no grant. First grant after reset goes to the lowest valid index.
